// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between packet requesters, the arbiter and the FIFO write-pointer logic.
// The slave modport is the arbiter's view; the master modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          wfull;
   logic                          winc;
   logic [DATA_WIDTH-1:0]         wdata;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;
   logic [CNT_WIDTH-1:0]          beat_cnt;
   logic                          timeout_err;

   modport slave (
      input  req_valid, req_data, req_last, wfull,
      output req_ready, winc, wdata, grant, busy, beat_cnt, timeout_err
   );

   modport master (
      output req_valid, req_data, req_last, wfull,
      input  req_ready, winc, wdata, grant, busy, beat_cnt, timeout_err
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the FIFO write port among NUM_REQ requesters.
// Optional grant timeout is built only when FIFO_WR_ARB_TIMEOUT_EN is defined.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic              wclk,
   input  logic              wrst_n,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CAND_W = IDX_W + 1;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_gidx;
   logic [IDX_W-1:0]     r_rr_last;
   logic [CNT_WIDTH-1:0] r_beat_cnt;

   logic                  w_busy;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_winc;
   logic                  w_found;
   logic [IDX_W-1:0]      w_next_idx;
   logic [CAND_W-1:0]     w_cand;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] r_idle_cnt;
   logic            r_timeout_err;
`endif

   // The one-hot grant doubles as the data/valid/last mux select and is zero while idle.
   assign w_busy      = (r_state == S_BURST);
   assign w_sel_valid = |(bus.req_valid & r_grant);
   assign w_sel_last  = |(bus.req_last & r_grant);
   assign w_winc      = w_busy & w_sel_valid & ~bus.wfull;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_data = w_sel_data | (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
      end
   end

   // Search starts just after the last owner and wraps, giving round-robin order.
   always_comb begin
      w_found    = 1'b0;
      w_next_idx = '0;
      w_cand     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, r_rr_last} + CAND_W'(k);
         if (w_cand >= CAND_W'(NUM_REQ)) w_cand = w_cand - CAND_W'(NUM_REQ);
         if (!w_found && bus.req_valid[w_cand[IDX_W-1:0]]) begin
            w_found    = 1'b1;
            w_next_idx = w_cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_gidx     <= '0;
         r_rr_last  <= IDX_W'(NUM_REQ - 1);
         r_beat_cnt <= '0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
         r_idle_cnt    <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_winc && (r_beat_cnt != '1)) r_beat_cnt <= r_beat_cnt + 1'b1;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_BURST;
                  r_gidx  <= w_next_idx;
                  r_grant <= NUM_REQ'(1) << w_next_idx;
               end
            end
            S_BURST: begin
               if (w_winc) begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
                  if (w_sel_last) begin
                     r_state   <= S_IDLE;
                     r_grant   <= '0;
                     r_rr_last <= r_gidx;
                  end
               end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
               // Only genuine requester silence counts; wfull stalls are not the owner's fault.
               else if (!w_sel_valid && !bus.wfull) begin
                  if (r_idle_cnt == TO_W'(TIMEOUT - 1)) begin
                     r_state       <= S_IDLE;
                     r_grant       <= '0;
                     r_rr_last     <= r_gidx;
                     r_idle_cnt    <= '0;
                     r_timeout_err <= 1'b1;
                  end else begin
                     r_idle_cnt <= r_idle_cnt + 1'b1;
                  end
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = r_grant & {NUM_REQ{~bus.wfull}};
   assign bus.winc      = w_winc;
   assign bus.wdata     = w_sel_data;
   assign bus.grant     = r_grant;
   assign bus.busy      = w_busy;
   assign bus.beat_cnt  = r_beat_cnt;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
   assign bus.timeout_err = r_timeout_err;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule
